// File: rtl/clk_sched_pkg.sv
// Shared types and defaults for the clock-domain scheduler: per-domain state
// encoding, domain index names and the round-robin wrap helper.
package clk_sched_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_IDLE = 2'd3
    } dom_state_t;

    localparam int DOM_FIR = 0;
    localparam int DOM_FFT = 1;
    localparam int DOM_DMA = 2;

    localparam int DEF_NUM_DOM     = 3;
    localparam int DEF_WAKE_CYCLES = 4;
    localparam int DEF_IDLE_CYCLES = 16;
    localparam int DEF_MAX_ACTIVE  = 2;
    localparam int DEF_CNT_W       = 8;

    // Wraps an index that has stepped at most one lap past the last domain.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage : clk_sched_pkg

// File: rtl/clk_domain_scheduler_if.sv
// Request/grant bundle between accelerator units (master) and the clock-domain
// scheduler (slave), plus the enable and budget status it publishes.
interface clk_domain_scheduler_if #(
    parameter int NUM_DOM = 3
);
    localparam int ACW = $clog2(NUM_DOM + 1);

    logic [NUM_DOM-1:0] req;
    logic [NUM_DOM-1:0] grant;
    logic [NUM_DOM-1:0] enable_out;
    logic [ACW-1:0]     active_cnt;
    logic               budget_full;

    modport master (
        output req,
        input  grant,
        input  enable_out,
        input  active_cnt,
        input  budget_full
    );

    modport slave (
        input  req,
        output grant,
        output enable_out,
        output active_cnt,
        output budget_full
    );

endinterface : clk_domain_scheduler_if

// File: rtl/clk_dom_fsm.sv
// Per-domain power sequencer: OFF -> WAKE -> ON <-> IDLE -> OFF, with wake and
// idle down-counters. enable, grant and active are registered alongside state.
module clk_dom_fsm
    import clk_sched_pkg::*;
#(
    parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk_in,
    input  logic reset_n,
    input  logic req,
    input  logic admit,
    input  logic force_on,
    output logic enable,
    output logic grant,
    output logic active
);

    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);

    dom_state_t       state;
    logic [CNT_W-1:0] wake_cnt;
    logic [CNT_W-1:0] idle_cnt;

    // NOTE: every register here uses <= so all branches read the pre-edge
    // state and counters; blocking writes would leak new values into later
    // decisions within the same edge.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_OFF;
            wake_cnt <= '0;
            idle_cnt <= '0;
            enable   <= 1'b0;
            grant    <= 1'b0;
            active   <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (admit || force_on) begin
                        state    <= ST_WAKE;
                        wake_cnt <= WAKE_LOAD;
                        enable   <= 1'b1;
                        active   <= 1'b1;
                    end
                end

                // The wake always runs to completion; req only picks the exit.
                ST_WAKE: begin
                    if (wake_cnt == '0) begin
                        if (req) begin
                            state <= ST_ON;
                            grant <= 1'b1;
                        end else begin
                            state    <= ST_IDLE;
                            idle_cnt <= IDLE_LOAD;
                        end
                    end else begin
                        wake_cnt <= wake_cnt - 1'b1;
                    end
                end

                ST_ON: begin
                    if (!req) begin
                        state    <= ST_IDLE;
                        grant    <= 1'b0;
                        idle_cnt <= IDLE_LOAD;
                    end
                end

                // A returning request beats the timeout, even on the last count.
                ST_IDLE: begin
                    if (req) begin
                        state    <= ST_ON;
                        grant    <= 1'b1;
                        idle_cnt <= '0;
                    end else if (idle_cnt == '0) begin
                        if (!force_on) begin
                            state  <= ST_OFF;
                            enable <= 1'b0;
                            active <= 1'b0;
                        end
                    end else begin
                        idle_cnt <= idle_cnt - 1'b1;
                    end
                end

                default: begin
                    state  <= ST_OFF;
                    enable <= 1'b0;
                    grant  <= 1'b0;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule : clk_dom_fsm

// File: rtl/clk_domain_scheduler.sv
// Clock-domain scheduler top: round-robin admission under an active-domain
// budget, one clk_dom_fsm per domain. Optional CLK_SCHED_FORCE_EN adds force_on.
module clk_domain_scheduler
    import clk_sched_pkg::*;
#(
    parameter int NUM_DOM     = DEF_NUM_DOM,
    parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int MAX_ACTIVE  = DEF_MAX_ACTIVE,
    parameter int CNT_W       = DEF_CNT_W
) (
    input logic                 clk_in,
    input logic                 reset_n,
`ifdef CLK_SCHED_FORCE_EN
    input logic [NUM_DOM-1:0]   force_on,
`endif
    clk_domain_scheduler_if.slave bus
);

    localparam int PTR_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam int ACW   = $clog2(NUM_DOM + 1);
    localparam logic [ACW-1:0] MAX_ACT = ACW'(MAX_ACTIVE);

    logic [NUM_DOM-1:0] force_vec;
    logic [NUM_DOM-1:0] dom_active;
    logic [NUM_DOM-1:0] dom_enable;
    logic [NUM_DOM-1:0] dom_grant;
    logic [NUM_DOM-1:0] cand;
    logic [NUM_DOM-1:0] admit;
    logic               admit_found;
    logic [PTR_W-1:0]   admit_idx;
    logic [PTR_W-1:0]   scan_idx;
    logic [PTR_W-1:0]   rr_ptr;
    logic [ACW-1:0]     active_cnt;
    logic               force_pending;

`ifdef CLK_SCHED_FORCE_EN
    assign force_vec = force_on;
`else
    assign force_vec = '0;
`endif

    // A forced wake-up claims the cycle, so no normal admission happens then.
    assign force_pending = |(force_vec & ~dom_active);
    assign cand          = bus.req & ~dom_active;

    // NOTE: every output of this block gets a default before any condition so
    // no path leaves a value held, which would otherwise infer a latch.
    always_comb begin
        int idx;
        idx         = 0;
        admit       = '0;
        admit_found = 1'b0;
        admit_idx   = '0;
        scan_idx    = '0;
        if (!force_pending && (active_cnt < MAX_ACT)) begin
            for (int i = 0; i < NUM_DOM; i++) begin
                idx      = rr_wrap(int'(rr_ptr) + i, NUM_DOM);
                scan_idx = PTR_W'(idx);
                if (!admit_found && cand[scan_idx]) begin
                    admit_found = 1'b1;
                    admit_idx   = scan_idx;
                end
            end
        end
        if (admit_found) begin
            admit[admit_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (admit_found) begin
            rr_ptr <= PTR_W'(rr_wrap(int'(admit_idx) + 1, NUM_DOM));
        end
    end

    // The active flags are registered, so the count follows state by one edge
    // and a slot freed this edge is only usable from the next one.
    always_comb begin
        active_cnt = '0;
        for (int i = 0; i < NUM_DOM; i++) begin
            active_cnt = active_cnt + ACW'(dom_active[i]);
        end
    end

    for (genvar g = 0; g < NUM_DOM; g++) begin : g_dom
        clk_dom_fsm #(
            .WAKE_CYCLES (WAKE_CYCLES),
            .IDLE_CYCLES (IDLE_CYCLES),
            .CNT_W       (CNT_W)
        ) u_fsm (
            .clk_in   (clk_in),
            .reset_n  (reset_n),
            .req      (bus.req[g]),
            .admit    (admit[g]),
            .force_on (force_vec[g]),
            .enable   (dom_enable[g]),
            .grant    (dom_grant[g]),
            .active   (dom_active[g])
        );
    end

    assign bus.grant      = dom_grant;
    assign bus.enable_out = dom_enable;
    assign bus.active_cnt = active_cnt;
`ifdef CLK_SCHED_FORCE_EN
    assign bus.budget_full = (active_cnt >= MAX_ACT);
`else
    assign bus.budget_full = (active_cnt == MAX_ACT);
`endif

endmodule : clk_domain_scheduler

// File: tb/tb_clk_domain_scheduler.sv
// Scoreboard bench: stimulus queues expected enable/grant edges with their
// cycle numbers; a negedge monitor matches every observed edge against them.
module tb_clk_domain_scheduler;
    import clk_sched_pkg::*;

    localparam int N = 3;

    logic clk_in  = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk_in = ~clk_in;

    clk_domain_scheduler_if #(.NUM_DOM(N)) if_a ();
    clk_domain_scheduler_if #(.NUM_DOM(N)) if_b ();

    // Unit 0: default configuration.
    clk_domain_scheduler #(
        .NUM_DOM(N), .WAKE_CYCLES(4), .IDLE_CYCLES(16), .MAX_ACTIVE(2), .CNT_W(8)
    ) u_dut_a (
        .clk_in  (clk_in),
        .reset_n (reset_n),
`ifdef CLK_SCHED_FORCE_EN
        .force_on('0),
`endif
        .bus     (if_a.slave)
    );

    // Unit 1: single-slot budget with short wake/idle for round-robin bursts.
    clk_domain_scheduler #(
        .NUM_DOM(N), .WAKE_CYCLES(2), .IDLE_CYCLES(2), .MAX_ACTIVE(1), .CNT_W(8)
    ) u_dut_b (
        .clk_in  (clk_in),
        .reset_n (reset_n),
`ifdef CLK_SCHED_FORCE_EN
        .force_on('0),
`endif
        .bus     (if_b.slave)
    );

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef enum int {EV_EN_RISE, EV_EN_FALL, EV_GR_RISE, EV_GR_FALL} ev_kind_t;
    typedef struct {
        int       unit;
        int       dom;
        ev_kind_t kind;
        int       at;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int unit, input int dom, input ev_kind_t kind, input int at);
        ev_t e;
        e.unit = unit;
        e.dom  = dom;
        e.kind = kind;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int unit, input int dom, input ev_kind_t kind, input int at);
        int idx;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (idx < 0 && exp_q[i].unit == unit && exp_q[i].dom == dom && exp_q[i].kind == kind)
                idx = i;
        end
        checks++;
        if (idx < 0) begin
            errors++;
            $display("FAIL ev u%0d d%0d %s: got edge at cycle %0d, expected none",
                     unit, dom, kind.name(), at);
        end else begin
            if (exp_q[idx].at != at) begin
                errors++;
                $display("FAIL ev u%0d d%0d %s: got cycle %0d, expected cycle %0d",
                         unit, dom, kind.name(), at, exp_q[idx].at);
            end
            exp_q.delete(idx);
        end
    endtask

    logic [N-1:0] prev_en [2];
    logic [N-1:0] prev_gr [2];
    logic [N-1:0] cur_en  [2];
    logic [N-1:0] cur_gr  [2];

    initial begin
        prev_en[0] = '0; prev_en[1] = '0;
        prev_gr[0] = '0; prev_gr[1] = '0;
    end

    always @(negedge clk_in) begin
        cur_en[0] = if_a.enable_out;
        cur_gr[0] = if_a.grant;
        cur_en[1] = if_b.enable_out;
        cur_gr[1] = if_b.grant;
        for (int u = 0; u < 2; u++) begin
            for (int d = 0; d < N; d++) begin
                if (cur_en[u][d] === 1'b1 && prev_en[u][d] !== 1'b1) observe(u, d, EV_EN_RISE, cyc);
                if (cur_en[u][d] === 1'b0 && prev_en[u][d] === 1'b1) observe(u, d, EV_EN_FALL, cyc);
                if (cur_gr[u][d] === 1'b1 && prev_gr[u][d] !== 1'b1) observe(u, d, EV_GR_RISE, cyc);
                if (cur_gr[u][d] === 1'b0 && prev_gr[u][d] === 1'b1) observe(u, d, EV_GR_FALL, cyc);
            end
            prev_en[u] = cur_en[u];
            prev_gr[u] = cur_gr[u];
        end
    end

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk_in);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got no end of stimulus by %0t, expected it earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a, b, d, e0, c2, c3, s2, c, r, q, s;

        if_a.req = '0;
        if_b.req = '0;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk_in);
        #1;
        check("reset grant",       int'(if_a.grant),       0);
        check("reset enable",      int'(if_a.enable_out),  0);
        check("reset active_cnt",  int'(if_a.active_cnt),  0);
        check("reset budget_full", int'(if_a.budget_full), 0);
        check("reset b active",    int'(if_b.active_cnt),  0);
        @(negedge clk_in);
        reset_n = 1'b1;

        // Round robin on unit 1: admissions 0,1,2,0, one every six cycles.
        @(negedge clk_in);
        a = cyc;
        if_b.req = '1;
        for (int k = 0; k < 4; k++) begin
            d = k % N;
            b = a + 1 + 6 * k;
            expect_ev(1, d, EV_EN_RISE, b);
            expect_ev(1, d, EV_GR_RISE, b + 2);
            expect_ev(1, d, EV_GR_FALL, b + 3);
            expect_ev(1, d, EV_EN_FALL, b + 5);
            wait_until(b + 2);
            if (k == 0) begin
                check("rr active_cnt", int'(if_b.active_cnt),  1);
                check("rr budget_full", int'(if_b.budget_full), 1);
            end
            if_b.req[d] = 1'b0;
            wait_until(b + 5);
            if (k < 3) if_b.req[d] = 1'b1;
            else       if_b.req = '0;
        end
        repeat (2) @(negedge clk_in);

        // Single wake on FIR.
        e0 = cyc + 1;
        if_a.req = 3'b001;
        expect_ev(0, DOM_FIR, EV_EN_RISE, e0);
        expect_ev(0, DOM_FIR, EV_GR_RISE, e0 + 4);
        wait_until(e0);
        check("wake active_cnt", int'(if_a.active_cnt), 1);
        wait_until(e0 + 4);

        // Idle rescue: request returns after five low cycles.
        c2 = cyc;
        if_a.req = 3'b000;
        expect_ev(0, DOM_FIR, EV_GR_FALL, c2 + 1);
        wait_until(c2 + 5);
        if_a.req = 3'b001;
        expect_ev(0, DOM_FIR, EV_GR_RISE, c2 + 6);
        wait_until(c2 + 6);
        check("rescue active_cnt", int'(if_a.active_cnt), 1);

        // Idle timeout: enable falls sixteen edges after grant falls.
        c3 = cyc;
        if_a.req = 3'b000;
        expect_ev(0, DOM_FIR, EV_GR_FALL, c3 + 1);
        expect_ev(0, DOM_FIR, EV_EN_FALL, c3 + 17);
        wait_until(c3 + 16);
        check("idle last-cycle active", int'(if_a.active_cnt), 1);
        wait_until(c3 + 17);
        check("timeout active_cnt", int'(if_a.active_cnt), 0);

        // One-cycle request: wake completes, then straight to idle and off.
        s2 = cyc;
        if_a.req = 3'b001;
        expect_ev(0, DOM_FIR, EV_EN_RISE, s2 + 1);
        expect_ev(0, DOM_FIR, EV_EN_FALL, s2 + 21);
        wait_until(s2 + 1);
        if_a.req = 3'b000;
        wait_until(s2 + 21);

        // Reset during FFT wake with the counter at 2.
        c = cyc;
        if_a.req = 3'b010;
        expect_ev(0, DOM_FFT, EV_EN_RISE, c + 1);
        expect_ev(0, DOM_FFT, EV_EN_FALL, c + 3);
        wait_until(c + 2);
        #2 reset_n = 1'b0;
        #1;
        check("midwake grant",       int'(if_a.grant),       0);
        check("midwake enable",      int'(if_a.enable_out),  0);
        check("midwake active_cnt",  int'(if_a.active_cnt),  0);
        check("midwake budget_full", int'(if_a.budget_full), 0);
        if_a.req = 3'b000;
        wait_until(c + 4);
        reset_n = 1'b1;

        // Budget: all three request from rr_ptr=0 right after reset.
        r = cyc;
        if_a.req = 3'b111;
        expect_ev(0, DOM_FIR, EV_EN_RISE, r + 1);
        expect_ev(0, DOM_FIR, EV_GR_RISE, r + 5);
        expect_ev(0, DOM_FFT, EV_EN_RISE, r + 2);
        expect_ev(0, DOM_FFT, EV_GR_RISE, r + 6);
        wait_until(r + 2);
        check("budget active_cnt",  int'(if_a.active_cnt),  2);
        check("budget budget_full", int'(if_a.budget_full), 1);
        wait_until(r + 6);
        q = cyc;
        if_a.req = 3'b110;
        expect_ev(0, DOM_FIR, EV_GR_FALL, q + 1);
        expect_ev(0, DOM_FIR, EV_EN_FALL, q + 17);
        expect_ev(0, DOM_DMA, EV_EN_RISE, q + 18);
        expect_ev(0, DOM_DMA, EV_GR_RISE, q + 22);
        wait_until(q + 17);
        check("slot freed active_cnt",  int'(if_a.active_cnt),  1);
        check("slot freed budget_full", int'(if_a.budget_full), 0);
        wait_until(q + 18);
        check("dma admitted active_cnt", int'(if_a.active_cnt), 2);
        wait_until(q + 22);
        s = cyc;
        if_a.req = 3'b000;
        expect_ev(0, DOM_FFT, EV_GR_FALL, s + 1);
        expect_ev(0, DOM_DMA, EV_GR_FALL, s + 1);
        expect_ev(0, DOM_FFT, EV_EN_FALL, s + 17);
        expect_ev(0, DOM_DMA, EV_EN_FALL, s + 17);
        wait_until(s + 17);
        check("drain active_cnt",  int'(if_a.active_cnt),  0);
        check("drain budget_full", int'(if_a.budget_full), 0);
        wait_until(s + 20);

        foreach (exp_q[i]) begin
            checks++;
            errors++;
            $display("FAIL ev u%0d d%0d %s: got none, expected cycle %0d",
                     exp_q[i].unit, exp_q[i].dom, exp_q[i].kind.name(), exp_q[i].at);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_clk_domain_scheduler

// File: doc/clk_domain_scheduler.md
Name: clk_domain_scheduler

Overview:
- Sequences the per-domain clock enables (FIR, FFT, DMA) that feed the gated-clock generator.
- Accelerator units request a clock over a req/grant handshake. The scheduler raises the domain enable and waits a fixed wake-up interval before granting.
- It turns idle domains off after a timeout and limits how many domains are active at once (power budget), using round-robin admission.

Parameters:
- NUM_DOM, 3, number of clock domains (index 0=FIR, 1=FFT, 2=DMA).
- WAKE_CYCLES, 4, cycles from enable rise to grant rise (1..255).
- IDLE_CYCLES, 16, consecutive req-low cycles before a domain turns off (1..255).
- MAX_ACTIVE, 2, maximum domains not in OFF at once (1..NUM_DOM).
- CNT_W, 8, width of the wake and idle counters.

Ports:
- clk_in, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- req, input, NUM_DOM, per-domain clock request (level).
- grant, output, NUM_DOM, domain clock is stable and usable.
- enable_out, output, NUM_DOM, level enable to the gated-clock generator.
- active_cnt, output, $clog2(NUM_DOM+1), number of domains not in OFF.
- budget_full, output, 1, active_cnt == MAX_ACTIVE.

Behaviour:
- Reset (async, reset_n=0):
  - All domains go to OFF; grant=0, enable_out=0, active_cnt=0, budget_full=0, rr_ptr=0.
  - Takes effect immediately, including mid-operation; no wake or idle sequence completes.
- Per-domain states: OFF, WAKE, ON, IDLE. All outputs are registered.
- OFF:
  - enable=0, grant=0.
  - Goes to WAKE when the domain requests and is admitted. Wake counter loads WAKE_CYCLES-1.
- Admission:
  - At most one OFF domain is admitted per cycle, and only if active_cnt < MAX_ACTIVE.
  - Among OFF domains with req=1, pick the first at or after rr_ptr (wrapping).
  - After an admission, rr_ptr = admitted index + 1 mod NUM_DOM.
  - A request that is not admitted stays pending with no error. A domain that leaves the budget in the same cycle does not free a slot until the next cycle.
- WAKE:
  - enable=1, grant=0. The counter decrements each cycle.
  - At 0: go to ON if req=1, otherwise go to IDLE (idle counter loaded).
  - Dropping req during WAKE never aborts the wake.
- Wake timing: req sampled high at edge t and admitted → enable_out high after edge t+1 → grant high after edge t+1+WAKE_CYCLES.
- ON:
  - enable=1, grant=1.
  - If req=0: go to IDLE and grant drops after the same edge. Idle counter loads IDLE_CYCLES-1.
- IDLE:
  - enable=1, grant=0.
  - If req=1: go to ON, grant re-asserts next cycle with no wake delay, and the counter clears.
  - Otherwise decrement. At 0 with req=0: go to OFF, enable drops.
  - If req=1 in the same cycle the counter hits 0, ON wins.
- Budget accounting:
  - active_cnt counts WAKE, ON and IDLE domains.
  - Changes are visible the cycle after the state change.
  - active_cnt never exceeds MAX_ACTIVE.
- A grant is always preceded by at least WAKE_CYCLES cycles of continuous enable.

Optional Feature:
- Macro: CLK_SCHED_FORCE_EN.
- When defined: adds input force_on [NUM_DOM].
  - A forced domain in OFF goes to WAKE regardless of budget or round-robin, with priority over the normal admission that cycle.
  - Forced domains never leave ON/IDLE via timeout; grant still follows req.
  - Forced domains do count in active_cnt, so active_cnt may exceed MAX_ACTIVE; budget_full = (active_cnt >= MAX_ACTIVE).
  - When force_on drops, normal timeout resumes.
- When undefined: no port, and behaviour is exactly as above.

Decomposition:
- Package clk_sched_pkg holds:
  - the dom_state_t enum (OFF, WAKE, ON, IDLE);
  - DOM_FIR/DOM_FFT/DOM_DMA index constants;
  - default WAKE/IDLE constants.
- Sub-module clk_dom_fsm: one per domain. Inputs are req, admit and force; it owns the state and both counters and drives enable, grant and active.
- The top level holds the round-robin admission arbiter, rr_ptr and the active_cnt adder.

Test Plan:
- Single wake: WAKE=4, req[0] rises at edge 0 → enable_out[0]=1 after edge 1, grant[0]=1 after edge 5, active_cnt=1.
- Idle timeout: IDLE=16, req[0] drops with domain ON → grant[0]=0 after next edge; enable_out[0]=0 exactly 16 cycles later; active_cnt returns to 0.
- Idle rescue: req[0] drops, then rises again 5 cycles later → grant[0] high the next cycle, no wake delay, enable_out never drops.
- Budget: MAX_ACTIVE=2, req=3'b111 simultaneously from rr_ptr=0:
  - domain 0 is admitted at cycle 1 and domain 1 at cycle 2; budget_full=1;
  - domain 2 waits until a domain reaches OFF, then is admitted the following cycle.
- Round-robin fairness: continuous contention with MAX_ACTIVE=1 and short activity bursts → admission order 0,1,2,0 and no starvation.
- Reset mid-wake: reset_n pulsed low during WAKE with counter=2 → grant=0, enable_out=0 and active_cnt=0 asynchronously; after release, a fresh req restarts the full WAKE_CYCLES sequence.
